// File: rtl/pulse_delay_gen_if.sv
// pulse_delay_gen_if: control/status bundle between a delay-generator user and pulse_delay_gen
interface pulse_delay_gen_if #(
  parameter int COARSE_BIT = 4,
  parameter int FINE_BIT   = 4
);
  logic                         LOAD;
  logic [COARSE_BIT+FINE_BIT-1:0] TIME;
  logic                         START;
  logic                         ABORT;
  logic                         PULSE;
  logic [FINE_BIT-1:0]          FINE_SEL;
  logic                         BUSY;
  logic                         ARMED_O;
  logic                         DONE;
  logic [7:0]                   MISSED;
  modport master (output LOAD, TIME, START, ABORT, input PULSE, FINE_SEL, BUSY, ARMED_O, DONE, MISSED);
  modport slave  (input LOAD, TIME, START, ABORT, output PULSE, FINE_SEL, BUSY, ARMED_O, DONE, MISSED);
endinterface

// File: rtl/pulse_delay_gen.sv
// pulse_delay_gen: emits PULSE a loaded number of clocks after a START rise, fine tap select on FINE_SEL
module pulse_delay_gen #(
  parameter int COARSE_BIT  = 4,
  parameter int FINE_BIT    = 4,
  parameter int PULSE_WIDTH = 2,
  parameter int REARM       = 0
) (
  input logic CLK,
  input logic RST,
  pulse_delay_gen_if.slave bus
);
  localparam int TW = COARSE_BIT + FINE_BIT;
  localparam int WW = $clog2(PULSE_WIDTH + 1);
  typedef enum logic [1:0] {IDLE, ARMED, COUNT, FIRE} state_t;
  state_t state, state_n;
  logic [TW-1:0] tim, tim_n;
  logic [COARSE_BIT-1:0] cnt, cnt_n, coarse;
  logic [WW-1:0] wcnt, wcnt_n;
  logic pulse, pulse_n, done, done_n, start_d, rise, busy;
  logic [7:0] missed, missed_n;
  assign coarse = tim[TW-1:FINE_BIT];
  assign rise = bus.START & ~start_d;
  assign busy = (state == COUNT) || (state == FIRE);
  always_comb begin
    state_n  = state;
    tim_n    = tim;
    cnt_n    = cnt;
    wcnt_n   = wcnt;
    pulse_n  = pulse;
    done_n   = 1'b0;
    missed_n = (rise && busy && missed != 8'hFF) ? missed + 8'd1 : missed;
    if (bus.ABORT) begin
      state_n = IDLE;
      pulse_n = 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.LOAD) begin
          tim_n   = bus.TIME;
          state_n = ARMED;
        end
        ARMED: if (rise) begin
          state_n = COUNT;
          cnt_n   = '0;
        end else if (bus.LOAD) tim_n = bus.TIME;
        COUNT: if (cnt == coarse) begin
          state_n = FIRE;
          pulse_n = 1'b1;
          wcnt_n  = WW'(1);
        end else cnt_n = cnt + 1'b1;
        FIRE: if (wcnt == WW'(PULSE_WIDTH)) begin
          pulse_n = 1'b0;
          done_n  = 1'b1;
          state_n = IDLE;
          if (REARM != 0) state_n = ARMED;
        end else wcnt_n = wcnt + 1'b1;
        default: state_n = IDLE;
      endcase
    end
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= IDLE;
      tim     <= '0;
      cnt     <= '0;
      wcnt    <= '0;
      pulse   <= 1'b0;
      done    <= 1'b0;
      missed  <= '0;
      start_d <= 1'b0;
    end else begin
      state   <= state_n;
      tim     <= tim_n;
      cnt     <= cnt_n;
      wcnt    <= wcnt_n;
      pulse   <= pulse_n;
      done    <= done_n;
      missed  <= missed_n;
      start_d <= bus.START;
    end
  end
  assign bus.PULSE    = pulse;
  assign bus.DONE     = done;
  assign bus.FINE_SEL = tim[FINE_BIT-1:0];
  assign bus.BUSY     = busy;
  assign bus.ARMED_O  = (state == ARMED);
  assign bus.MISSED   = missed;
endmodule

// File: tb/tb_pulse_delay_gen.sv
// tb_pulse_delay_gen: directed vectors for single-shot and re-arming delay generators
module tb_pulse_delay_gen;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  int vectors = 0;
  int errs = 0;
  always #5 CLK = ~CLK;
  pulse_delay_gen_if a_if ();
  pulse_delay_gen_if b_if ();
  pulse_delay_gen #(.REARM(0)) dut_a (.CLK(CLK), .RST(RST), .bus(a_if));
  pulse_delay_gen #(.REARM(1)) dut_b (.CLK(CLK), .RST(RST), .bus(b_if));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask
  task automatic watch(input int c, input int n);
    for (int i = 1; i <= n; i++) begin
      tick();
      check("pulse", a_if.PULSE, 32'(i >= c + 1 && i <= c + 2));
      check("done", a_if.DONE, 32'(i == c + 3));
    end
  endtask
  task automatic fire(input logic [7:0] t);
    a_if.TIME = t;
    a_if.LOAD = 1'b1;
    tick();
    a_if.LOAD = 1'b0;
    check("fine_sel", a_if.FINE_SEL, 32'(t[3:0]));
    check("armed", a_if.ARMED_O, 1);
    a_if.START = 1'b1;
    tick();
    a_if.START = 1'b0;
    check("busy", a_if.BUSY, 1);
    watch(int'(t[7:4]), int'(t[7:4]) + 4);
    check("idle", {a_if.BUSY, a_if.ARMED_O}, 0);
    check("fine_hold", a_if.FINE_SEL, 32'(t[3:0]));
  endtask
  initial begin
    {a_if.LOAD, a_if.TIME, a_if.START, a_if.ABORT} = '0;
    {b_if.LOAD, b_if.TIME, b_if.START, b_if.ABORT} = '0;
    tick();
    tick();
    check("rst_out", {a_if.PULSE, a_if.BUSY, a_if.ARMED_O, a_if.DONE, a_if.FINE_SEL, a_if.MISSED}, 0);
    RST = 1'b0;
    tick();
    check("idle_out", {a_if.PULSE, a_if.BUSY, a_if.ARMED_O, a_if.DONE}, 0);
    fire(8'h35);
    fire(8'h0A);
    fire(8'hF0);
    b_if.TIME = 8'h21;
    b_if.LOAD = 1'b1;
    tick();
    b_if.LOAD = 1'b0;
    check("b_fine", b_if.FINE_SEL, 1);
    for (int k = 0; k < 3; k++) begin
      b_if.START = 1'b1;
      tick();
      b_if.START = 1'b0;
      check("b_busy", b_if.BUSY, 1);
      for (int i = 1; i <= 9; i++) begin
        tick();
        check("b_pulse", b_if.PULSE, 32'(i == 3 || i == 4));
        check("b_done", b_if.DONE, 32'(i == 5));
      end
      check("b_armed", {b_if.ARMED_O, b_if.BUSY}, 2);
      check("b_fine_hold", b_if.FINE_SEL, 1);
    end
    a_if.TIME = 8'h80;
    a_if.LOAD = 1'b1;
    tick();
    a_if.LOAD = 1'b0;
    a_if.START = 1'b1;
    tick();
    for (int i = 1; i <= 11; i++) begin
      a_if.START = (i == 3);
      a_if.LOAD = (i == 5);
      a_if.TIME = (i == 5) ? 8'h11 : 8'h80;
      tick();
      check("busy_pulse", a_if.PULSE, 32'(i == 9 || i == 10));
      check("busy_done", a_if.DONE, 32'(i == 11));
    end
    a_if.LOAD = 1'b0;
    check("missed", a_if.MISSED, 1);
    check("busy_fine", a_if.FINE_SEL, 0);
    a_if.TIME = 8'h60;
    a_if.LOAD = 1'b1;
    tick();
    a_if.LOAD = 1'b0;
    a_if.START = 1'b1;
    tick();
    a_if.START = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      a_if.ABORT = (i == 3);
      tick();
      check("abort_pulse", {a_if.PULSE, a_if.DONE}, 0);
      if (i >= 3) check("abort_idle", {a_if.BUSY, a_if.ARMED_O}, 0);
    end
    a_if.ABORT = 1'b0;
    a_if.START = 1'b1;
    tick();
    a_if.START = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      check("noload_pulse", {a_if.PULSE, a_if.BUSY}, 0);
    end
    a_if.TIME = 8'h60;
    a_if.LOAD = 1'b1;
    tick();
    a_if.LOAD = 1'b0;
    a_if.START = 1'b1;
    tick();
    a_if.START = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      a_if.ABORT = (i == 8);
      tick();
      check("trunc_pulse", a_if.PULSE, 32'(i == 7));
      check("trunc_done", a_if.DONE, 0);
    end
    a_if.ABORT = 1'b0;
    a_if.TIME = 8'h60;
    a_if.LOAD = 1'b1;
    tick();
    a_if.LOAD = 1'b0;
    a_if.START = 1'b1;
    tick();
    tick();
    tick();
    check("pre_rst_busy", a_if.BUSY, 1);
    #3;
    RST = 1'b1;
    #1;
    check("async_rst", {a_if.PULSE, a_if.BUSY, a_if.ARMED_O, a_if.DONE, a_if.FINE_SEL, a_if.MISSED}, 0);
    tick();
    tick();
    #3;
    RST = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      check("post_rst", {a_if.PULSE, a_if.BUSY, a_if.ARMED_O, a_if.DONE}, 0);
    end
    check("post_rst_missed", a_if.MISSED, 0);
    a_if.START = 1'b0;
    tick();
    a_if.START = 1'b1;
    tick();
    a_if.START = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      check("rst_noload", {a_if.PULSE, a_if.BUSY}, 0);
    end
    fire(8'h35);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
